// File: rtl/mux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_sched
// Purpose  : Round-robin scheduler that shares one 4-to-1 mux between four
//            requesters. It drives the mux select lines directly and limits
//            each owner's tenure to MAX_HOLD consecutive cycles.
// Ports    : clock     - system clock, all state updates on posedge
//            reset     - synchronous, active-high reset
//            req[3:0]  - request vector, req[n] = requester n wants the mux
//            gnt[3:0]  - one-hot grant, all-zero when nobody owns the mux
//            s1, s0    - mux select = owner index (held while idle)
//            sel_valid - high while some requester owns the mux (= |gnt)
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_sched #(
  parameter int MAX_HOLD = 4,  // legal 1 .. 2**HOLD_W
  parameter int HOLD_W   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       sel_valid
);

  // Last cycle of a tenure; MAX_HOLD-1 always fits in HOLD_W bits.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_q;
  logic [3:0]        gnt_q;
  logic [1:0]        sel_q;
  logic              sel_valid_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [1:0]        last_q;

  logic [1:0]        search_start;
  logic [1:0]        scan_idx;
  logic [1:0]        win_d;
  logic              win_found;
  logic              release_d;

  // While granting, last_q always equals the current owner, so a single
  // search start of last+1 serves both the idle and the re-arbitration case.
  assign search_start = last_q + 2'd1;

  // Cyclic priority search: first set request bit at or after search_start.
  always_comb begin
    win_d     = search_start;
    win_found = 1'b0;
    scan_idx  = search_start;
    for (int k = 0; k < 4; k++) begin
      scan_idx = search_start + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_d     = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Owner lets go when it stops requesting or its tenure is used up.
  assign release_d = !req[sel_q] || (cnt_q == HOLD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'b00;
      sel_valid_q <= 1'b0;
      cnt_q       <= '0;
      last_q      <= 2'd3;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q     <= ST_GRANT;
            gnt_q       <= 4'b0001 << win_d;
            sel_q       <= win_d;
            sel_valid_q <= 1'b1;
            cnt_q       <= '0;
            last_q      <= win_d;
          end
        end
        ST_GRANT: begin
          if (!release_d) begin
            cnt_q <= cnt_q + HOLD_W'(1);
          end else if (win_found) begin
            // Hand over on the same edge (no bubble); may re-grant the owner.
            gnt_q       <= 4'b0001 << win_d;
            sel_q       <= win_d;
            sel_valid_q <= 1'b1;
            cnt_q       <= '0;
            last_q      <= win_d;
          end else begin
            // Nobody requesting: drop grant, keep select lines on old owner.
            state_q     <= ST_IDLE;
            gnt_q       <= 4'b0000;
            sel_valid_q <= 1'b0;
            cnt_q       <= '0;
            last_q      <= sel_q;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          gnt_q       <= 4'b0000;
          sel_valid_q <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign sel_valid = sel_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_sched
// Purpose  : Self-checking bench for mux4_rr_sched. A behavioural reference
//            model predicts each cycle's outputs into a scoreboard queue when
//            stimulus is driven; the entry is popped and compared after the
//            clock edge. Directed checks pin down the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_sched;

  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 3;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       sel_valid;

  mux4_rr_sched #(
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (HOLD_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .s1       (s1),
    .s0       (s0),
    .sel_valid(sel_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: owner index (-1 = none), select, counter, last.
  int         m_owner = -1;
  logic [1:0] m_sel   = 2'b00;
  int         m_cnt   = 0;
  int         m_last  = 3;

  function automatic int m_search(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [3:0] r, input logic rst);
    int w;
    if (rst) begin
      m_owner = -1; m_sel = 2'b00; m_cnt = 0; m_last = 3;
    end else if (m_owner < 0) begin
      w = m_search(r, (m_last + 1) % 4);
      if (w >= 0) begin
        m_owner = w; m_sel = 2'(w); m_cnt = 0; m_last = w;
      end
    end else if (r[m_owner] && (m_cnt < MAX_HOLD - 1)) begin
      m_cnt = m_cnt + 1;
    end else begin
      w = m_search(r, (m_owner + 1) % 4);
      if (w >= 0) begin
        m_owner = w; m_sel = 2'(w); m_cnt = 0; m_last = w;
      end else begin
        m_last = m_owner; m_owner = -1; m_cnt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, sample 1ns after posedge.
  task automatic step(input logic [3:0] r, input logic rst);
    exp_t       e;
    logic [1:0] prev_sel;
    logic [3:0] prev_gnt;
    @(negedge clock);
    req   = r;
    reset = rst;
    model_update(r, rst);
    e.gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.sel = m_sel;
    e.vld = (m_owner >= 0);
    sb.push_back(e);
    prev_sel = {s1, s0};
    prev_gnt = gnt;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("sb_gnt", {4'b0, gnt}, {4'b0, e.gnt});
    chk("sb_sel", {6'b0, s1, s0}, {6'b0, e.sel});
    chk("sb_vld", {7'b0, sel_valid}, {7'b0, e.vld});
    // Structural invariants independent of the model.
    chk("inv_onehot0", {7'b0, $onehot0(gnt)}, 8'd1);
    chk("inv_vld_or", {7'b0, sel_valid}, {7'b0, |gnt});
    if (sel_valid === 1'b1)
      chk("inv_sel_idx", {4'b0, gnt}, {4'b0, 4'b0001 << {s1, s0}});
    if ({s1, s0} !== prev_sel)
      chk("inv_sel_chg", {7'b0, rst || ((|gnt) && (gnt !== prev_gnt))}, 8'd1);
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    // Reset state.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("rst_gnt", {4'b0, gnt}, 8'b0000_0000);
    chk("rst_sel", {6'b0, s1, s0}, 8'd0);
    chk("rst_vld", {7'b0, sel_valid}, 8'd0);

    // Two requesters alternate every MAX_HOLD cycles.
    for (int i = 1; i <= 12; i++) begin
      step(4'b0101, 1'b0);
      chk("tp_0101_gnt", {4'b0, gnt}, (i <= 4 || i > 8) ? 8'b0000_0001 : 8'b0000_0100);
      if (i == 5) chk("tp_0101_sel", {6'b0, s1, s0}, 8'd2);
    end

    // Lone requester is re-granted continuously, never idle.
    step(4'b0000, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step(4'b0001, 1'b0);
      chk("tp_solo_gnt", {4'b0, gnt}, 8'b0000_0001);
      chk("tp_solo_vld", {7'b0, sel_valid}, 8'd1);
    end

    // All four requesting: 0,1,2,3,0 with MAX_HOLD cycles each.
    step(4'b0000, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(4'b1111, 1'b0);
      chk("tp_all_sel", {6'b0, s1, s0}, 8'((i / MAX_HOLD) % 4));
      chk("tp_all_vld", {7'b0, sel_valid}, 8'd1);
    end

    // Owner 2 drops its request early; owner 3 takes over with no bubble.
    step(4'b0000, 1'b1);
    step(4'b1100, 1'b0);
    chk("tp_drop_own2", {4'b0, gnt}, 8'b0000_0100);
    step(4'b1100, 1'b0);
    step(4'b1000, 1'b0);
    chk("tp_drop_gnt", {4'b0, gnt}, 8'b0000_1000);
    chk("tp_drop_sel", {6'b0, s1, s0}, 8'd3);
    chk("tp_drop_vld", {7'b0, sel_valid}, 8'd1);

    // Reset in the middle of a grant to requester 2.
    step(4'b0000, 1'b1);
    for (int i = 0; i < 9; i++) step(4'b1111, 1'b0);
    chk("tp_mid_pre", {4'b0, gnt}, 8'b0000_0100);
    step(4'b1111, 1'b1);
    chk("tp_mid_gnt", {4'b0, gnt}, 8'b0000_0000);
    chk("tp_mid_sel", {6'b0, s1, s0}, 8'd0);
    chk("tp_mid_vld", {7'b0, sel_valid}, 8'd0);
    step(4'b1111, 1'b0);
    chk("tp_mid_post", {4'b0, gnt}, 8'b0000_0001);

    // Owner 3 goes idle, select holds, then search restarts from 0.
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    chk("tp_idle_gnt", {4'b0, gnt}, 8'b0000_0000);
    chk("tp_idle_sel", {6'b0, s1, s0}, 8'd3);
    chk("tp_idle_vld", {7'b0, sel_valid}, 8'd0);
    step(4'b0000, 1'b0);
    chk("tp_idle_hold", {6'b0, s1, s0}, 8'd3);
    step(4'b1001, 1'b0);
    chk("tp_wake_gnt", {4'b0, gnt}, 8'b0000_0001);
    chk("tp_wake_sel", {6'b0, s1, s0}, 8'd0);

    // Random traffic against the reference model, occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
